// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the memory-access stage: the mem_opt width and
//   operation encodings, plus small helpers that classify an operation.
//   Imported by mem_stage and mem_byte_lane.
package mem_stage_pkg;

    localparam int MEM_OPT_WIDTH = 3;

    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE = 3'd0;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LW   = 3'd1;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SW   = 3'd2;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LB   = 3'd3;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LBU  = 3'd4;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SB   = 3'd5;

    // Encodings above MEM_OPT_SB are unassigned.
    function automatic logic is_legal_op(input logic [MEM_OPT_WIDTH-1:0] op);
        return op <= MEM_OPT_SB;
    endfunction

    // Word ops are the only ones subject to the alignment check.
    function automatic logic is_word_op(input logic [MEM_OPT_WIDTH-1:0] op);
        return (op == MEM_OPT_LW) || (op == MEM_OPT_SW);
    endfunction

    function automatic logic is_store_op(input logic [MEM_OPT_WIDTH-1:0] op);
        return (op == MEM_OPT_SW) || (op == MEM_OPT_SB);
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane
//   Purely combinational lane steering for the memory stage.
//   Store side : st_op, st_addr_lo, st_data -> st_byte_en, st_wdata
//                (word ops use all lanes; SB replicates the low byte to
//                every lane and enables only the addressed one).
//   Load side  : ld_op, ld_addr_lo, ld_rdata -> ld_result
//                (LW passes the word; LB sign-extends, LBU zero-extends
//                the addressed little-endian lane).
module mem_byte_lane
    import mem_stage_pkg::*;
(
    input  logic [MEM_OPT_WIDTH-1:0] st_op,
    input  logic [1:0]               st_addr_lo,
    input  logic [31:0]              st_data,
    output logic [3:0]               st_byte_en,
    output logic [31:0]              st_wdata,
    input  logic [MEM_OPT_WIDTH-1:0] ld_op,
    input  logic [1:0]               ld_addr_lo,
    input  logic [31:0]              ld_rdata,
    output logic [31:0]              ld_result
);

    logic [7:0] ld_byte;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        st_byte_en = 4'b0000;
        st_wdata   = 32'h0;
        case (st_op)
            MEM_OPT_LW: st_byte_en = 4'b1111;
            MEM_OPT_SW: begin
                st_byte_en = 4'b1111;
                st_wdata   = st_data;
            end
            MEM_OPT_LB, MEM_OPT_LBU: st_byte_en = 4'b0001 << st_addr_lo;
            MEM_OPT_SB: begin
                st_byte_en = 4'b0001 << st_addr_lo;
                st_wdata   = {4{st_data[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[8*ld_addr_lo +: 8];
        case (ld_op)
            MEM_OPT_LW:  ld_result = ld_rdata;
            MEM_OPT_LB:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            MEM_OPT_LBU: ld_result = {24'h0, ld_byte};
            default:     ld_result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access stage: takes the ALU result as an address (or a
//   pass-through value), performs word/byte loads and stores over a
//   single-outstanding req/ack bus, and emits a one-cycle writeback pulse.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     in_valid/in_ready        upstream handshake; in_ready low while a
//                              bus transaction is pending
//     alu_result, store_data,
//     mem_opt, wb_reg_in       instruction fields, latched on acceptance
//     bus_req/we/addr/byte_en/
//     wdata, bus_ack, bus_rdata  single-outstanding memory bus
//     out_valid/result/wb_reg  one-cycle writeback pulse
//     exc_addr_err/badvaddr    one-cycle misaligned word-access pulse
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              alu_result,
    input  logic [31:0]              store_data,
    input  logic [MEM_OPT_WIDTH-1:0] mem_opt,
    input  logic [4:0]               wb_reg_in,
    output logic                     bus_req,
    output logic                     bus_we,
    output logic [31:0]              bus_addr,
    output logic [3:0]               bus_byte_en,
    output logic [31:0]              bus_wdata,
    input  logic                     bus_ack,
    input  logic [31:0]              bus_rdata,
    output logic                     out_valid,
    output logic [31:0]              out_result,
    output logic [4:0]               out_wb_reg,
    output logic                     exc_addr_err,
    output logic [31:0]              exc_badvaddr
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    state_e state, next_state;

    logic                     accept;
    logic [MEM_OPT_WIDTH-1:0] eff_op;
    logic                     misaligned;
    logic                     launch;
    logic                     ack_seen;

    // Instruction fields held for the duration of a bus transaction.
    logic [MEM_OPT_WIDTH-1:0] pend_op;
    logic [1:0]               pend_off;
    logic [4:0]               pend_wb_reg;

    logic [3:0]  st_byte_en;
    logic [31:0] st_wdata;
    logic [31:0] ld_result;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready;
    // Unassigned encodings behave exactly like NONE.
    assign eff_op     = is_legal_op(mem_opt) ? mem_opt : MEM_OPT_NONE;
    assign misaligned = is_word_op(eff_op) && (alu_result[1:0] != 2'b00);
    assign launch     = (eff_op != MEM_OPT_NONE) && !misaligned;
    // Only meaningful while a request is outstanding; stray acks are dropped.
    assign ack_seen   = (state == WAIT_ACK) && bus_ack;

    mem_byte_lane u_lane (
        .st_op      (eff_op),
        .st_addr_lo (alu_result[1:0]),
        .st_data    (store_data),
        .st_byte_en (st_byte_en),
        .st_wdata   (st_wdata),
        .ld_op      (pend_op),
        .ld_addr_lo (pend_off),
        .ld_rdata   (bus_rdata),
        .ld_result  (ld_result)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept && launch) next_state = WAIT_ACK;
            WAIT_ACK: if (bus_ack)          next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // The async reset clears bus_req immediately, abandoning any pending
    // transaction without a writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0;
            bus_byte_en  <= 4'h0;
            bus_wdata    <= 32'h0;
            out_valid    <= 1'b0;
            out_result   <= 32'h0;
            out_wb_reg   <= 5'd0;
            exc_addr_err <= 1'b0;
            exc_badvaddr <= 32'h0;
            pend_op      <= MEM_OPT_NONE;
            pend_off     <= 2'b00;
            pend_wb_reg  <= 5'd0;
        end else begin
            // Writeback and exception are single-cycle pulses.
            out_valid    <= 1'b0;
            exc_addr_err <= 1'b0;
            if (accept) begin
                if (launch) begin
                    bus_req     <= 1'b1;
                    bus_we      <= is_store_op(eff_op);
                    bus_addr    <= {alu_result[31:2], 2'b00};
                    bus_byte_en <= st_byte_en;
                    bus_wdata   <= st_wdata;
                    pend_op     <= eff_op;
                    pend_off    <= alu_result[1:0];
                    pend_wb_reg <= wb_reg_in;
                end else if (misaligned) begin
                    out_valid    <= 1'b1;
                    out_result   <= 32'h0;
                    out_wb_reg   <= 5'd0;
                    exc_addr_err <= 1'b1;
                    exc_badvaddr <= alu_result;
                end else begin
                    out_valid  <= 1'b1;
                    out_result <= alu_result;
                    out_wb_reg <= wb_reg_in;
                end
            end else if (ack_seen) begin
                bus_req   <= 1'b0;
                bus_we    <= 1'b0;
                out_valid <= 1'b1;
                if (is_store_op(pend_op)) begin
                    out_result <= 32'h0;
                    out_wb_reg <= 5'd0;
                end else begin
                    out_result <= ld_result;
                    out_wb_reg <= pend_wb_reg;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && accept && !is_legal_op(mem_opt)) begin
            $warning("mem_stage: illegal mem_opt %0d treated as NONE", mem_opt);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              alu_result;
    logic [31:0]              store_data;
    logic [MEM_OPT_WIDTH-1:0] mem_opt;
    logic [4:0]               wb_reg_in;
    logic                     bus_req;
    logic                     bus_we;
    logic [31:0]              bus_addr;
    logic [3:0]               bus_byte_en;
    logic [31:0]              bus_wdata;
    logic                     bus_ack;
    logic [31:0]              bus_rdata;
    logic                     out_valid;
    logic [31:0]              out_result;
    logic [4:0]               out_wb_reg;
    logic                     exc_addr_err;
    logic [31:0]              exc_badvaddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .mem_opt      (mem_opt),
        .wb_reg_in    (wb_reg_in),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_byte_en  (bus_byte_en),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .out_wb_reg   (out_wb_reg),
        .exc_addr_err (exc_addr_err),
        .exc_badvaddr (exc_badvaddr)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle; returns just after the
    // accepting edge, when the registered response is visible.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] wb);
        in_valid   = 1'b1;
        mem_opt    = op;
        alu_result = addr;
        store_data = sdata;
        wb_reg_in  = wb;
        tick();
        in_valid   = 1'b0;
    endtask

    // Pulse bus_ack for one cycle with the given read data.
    task automatic ack(input logic [31:0] rdata);
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        tick();
        bus_ack   = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b exp 0", bus_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (exc_addr_err !== 1'b0) begin errors++; $display("FAIL reset_exc got %b exp 0", exc_addr_err); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h exp 0", out_result); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got %h exp 0", bus_addr); end
    endtask

    task automatic test_none();
        issue(MEM_OPT_NONE, 32'h1234_5678, 32'h0, 5'd3);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL none_valid got %b exp 1", out_valid); end
        checks++; if (out_result !== 32'h1234_5678) begin errors++; $display("FAIL none_result got %h exp 12345678", out_result); end
        checks++; if (out_wb_reg !== 5'd3) begin errors++; $display("FAIL none_wb_reg got %0d exp 3", out_wb_reg); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL none_bus_req got %b exp 0", bus_req); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL none_pulse got %b exp 0", out_valid); end
    endtask

    task automatic test_lw();
        int low_cnt = 0;
        issue(MEM_OPT_LW, 32'h100, 32'h0, 5'd9);
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL lw_req got %b exp 1", bus_req); end
        checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h exp 100", bus_addr); end
        checks++; if (bus_byte_en !== 4'b1111) begin errors++; $display("FAIL lw_byte_en got %b exp 1111", bus_byte_en); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL lw_we got %b exp 0", bus_we); end
        for (int i = 0; i < 3; i++) begin
            if (!in_ready) low_cnt++;
            tick();
        end
        checks++; if (bus_addr !== 32'h100 || bus_req !== 1'b1) begin errors++; $display("FAIL lw_hold got req %b addr %h exp 1 100", bus_req, bus_addr); end
        if (!in_ready) low_cnt++;
        ack(32'hDEAD_BEEF);
        checks++; if (low_cnt !== 4) begin errors++; $display("FAIL lw_stall got %0d exp 4", low_cnt); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_valid got %b exp 1", out_valid); end
        checks++; if (out_result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_result got %h exp deadbeef", out_result); end
        checks++; if (out_wb_reg !== 5'd9) begin errors++; $display("FAIL lw_wb_reg got %0d exp 9", out_wb_reg); end
        checks++; if (bus_req !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL lw_release got req %b ready %b exp 0 1", bus_req, in_ready); end
    endtask

    // Ack in the first request cycle: minimum 2-cycle latency.
    task automatic test_byte_loads();
        issue(MEM_OPT_LB, 32'h103, 32'h0, 5'd4);
        checks++; if (bus_addr !== 32'h100 || bus_byte_en !== 4'b1000) begin errors++; $display("FAIL lb_bus got addr %h en %b exp 100 1000", bus_addr, bus_byte_en); end
        ack(32'h8012_3456);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_result got v%b %h exp v1 ffffff80", out_valid, out_result); end
        issue(MEM_OPT_LBU, 32'h103, 32'h0, 5'd5);
        ack(32'h8012_3456);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h0000_0080) begin errors++; $display("FAIL lbu_result got v%b %h exp v1 00000080", out_valid, out_result); end
        checks++; if (out_wb_reg !== 5'd5) begin errors++; $display("FAIL lbu_wb_reg got %0d exp 5", out_wb_reg); end
        issue(MEM_OPT_LB, 32'h101, 32'h0, 5'd6);
        ack(32'h0000_7F00);
        checks++; if (exc_addr_err !== 1'b0 || out_result !== 32'h0000_007F) begin errors++; $display("FAIL lb_lane1 got exc %b %h exp 0 0000007f", exc_addr_err, out_result); end
    endtask

    task automatic test_stores();
        issue(MEM_OPT_SB, 32'h202, 32'h1234_56A5, 5'd7);
        checks++; if (bus_addr !== 32'h200) begin errors++; $display("FAIL sb_addr got %h exp 200", bus_addr); end
        checks++; if (bus_byte_en !== 4'b0100) begin errors++; $display("FAIL sb_byte_en got %b exp 0100", bus_byte_en); end
        checks++; if (bus_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", bus_wdata); end
        checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL sb_we got %b exp 1", bus_we); end
        tick();
        ack(32'hFFFF_FFFF);
        checks++; if (out_valid !== 1'b1 || out_wb_reg !== 5'd0) begin errors++; $display("FAIL sb_wb got v%b reg %0d exp v1 0", out_valid, out_wb_reg); end
        issue(MEM_OPT_SW, 32'h304, 32'h1122_3344, 5'd8);
        checks++; if (bus_wdata !== 32'h1122_3344 || bus_byte_en !== 4'b1111 || bus_addr !== 32'h304) begin errors++; $display("FAIL sw_bus got %h %b %h exp 11223344 1111 304", bus_wdata, bus_byte_en, bus_addr); end
        ack(32'h0);
        checks++; if (out_wb_reg !== 5'd0) begin errors++; $display("FAIL sw_wb got %0d exp 0", out_wb_reg); end
    endtask

    task automatic test_misaligned();
        issue(MEM_OPT_LW, 32'h101, 32'h0, 5'd2);
        checks++; if (exc_addr_err !== 1'b1) begin errors++; $display("FAIL mis_lw_exc got %b exp 1", exc_addr_err); end
        checks++; if (exc_badvaddr !== 32'h101) begin errors++; $display("FAIL mis_lw_badv got %h exp 101", exc_badvaddr); end
        checks++; if (bus_req !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mis_lw_bus got req %b ready %b exp 0 1", bus_req, in_ready); end
        checks++; if (out_valid !== 1'b1 || out_wb_reg !== 5'd0) begin errors++; $display("FAIL mis_lw_wb got v%b reg %0d exp v1 0", out_valid, out_wb_reg); end
        issue(MEM_OPT_SW, 32'h402, 32'h5, 5'd0);
        checks++; if (exc_addr_err !== 1'b1 || exc_badvaddr !== 32'h402 || bus_req !== 1'b0) begin errors++; $display("FAIL mis_sw got exc %b %h req %b exp 1 402 0", exc_addr_err, exc_badvaddr, bus_req); end
        tick();
        checks++; if (exc_addr_err !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b exp 0", exc_addr_err); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; mem_opt = MEM_OPT_NONE; alu_result = 32'hA; wb_reg_in = 5'd10;
        tick();
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hA || out_wb_reg !== 5'd10) begin errors++; $display("FAIL b2b_first got v%b %h %0d exp v1 a 10", out_valid, out_result, out_wb_reg); end
        mem_opt = 3'd7; alu_result = 32'hB; wb_reg_in = 5'd11;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hB || out_wb_reg !== 5'd11 || bus_req !== 1'b0) begin errors++; $display("FAIL b2b_illegal got v%b %h %0d req %b exp v1 b 11 0", out_valid, out_result, out_wb_reg, bus_req); end
    endtask

    task automatic test_stray_ack();
        ack(32'h1234);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stray_ack got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue(MEM_OPT_LW, 32'h500, 32'h0, 5'd12);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_async_req got %b exp 0", bus_req); end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_ack = (i == 1);
            tick();
            if (out_valid) seen++;
        end
        bus_ack = 1'b0;
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_valid got %0d exp 0", seen); end
        issue(MEM_OPT_NONE, 32'h77, 32'h0, 5'd13);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h77 || out_wb_reg !== 5'd13) begin errors++; $display("FAIL rst_recover got v%b %h %0d exp v1 77 13", out_valid, out_result, out_wb_reg); end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        alu_result = 32'h0;
        store_data = 32'h0;
        mem_opt    = MEM_OPT_NONE;
        wb_reg_in  = 5'd0;
        bus_ack    = 1'b0;
        bus_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
        test_reset();
        test_none();
        test_lw();
        test_byte_loads();
        test_stores();
        test_misaligned();
        test_back_to_back();
        test_stray_ack();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
